// File: rtl/wbuf_bank_seq_pkg.sv
// Shared types and constant helpers for the weight-buffer bank sequencer.
package wbuf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } wbuf_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Radix-4 Booth recoding: one 3-bit {neg, two, one} code per digit pair.
  function automatic int bpr_width(input int weight_width);
    return ((weight_width + 1) / 2) * 3;
  endfunction

endpackage

// File: rtl/wbuf_bank_seq_enc.sv
// Radix-4 Booth encoder with precision trimming and nonzero-term count.
module BPEB_Enc_ETC #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int BPR_WIDTH    = 24,
  parameter int ETC_WIDTH    = 4
) (
  input  logic [WEIGHT_WIDTH-1:0] i_weight,
  input  logic [3:0]              i_n_ap,
  output logic [BPR_WIDTH-1:0]    o_bpr,
  output logic [ETC_WIDTH-1:0]    o_etc
);

  localparam int NDIG  = BPR_WIDTH / 3;
  localparam int EXT_W = 2 * NDIG + 1;

  logic [EXT_W-1:0] w_ext;
  logic [2:0]       w_trip;
  logic [2:0]       w_dig;

  // Per digit: code {neg,two,one}; n_ap=0 keeps all digits, otherwise only the top n_ap positions.
  always_comb begin
    w_ext  = EXT_W'($signed({i_weight, 1'b0}));
    w_trip = 3'b000;
    w_dig  = 3'b000;
    o_bpr  = '0;
    o_etc  = '0;
    for (int j = 0; j < NDIG; j++) begin
      w_trip = w_ext[2*j+2 -: 3];
      case (w_trip)
        3'b001, 3'b010: w_dig = 3'b001;
        3'b011:         w_dig = 3'b010;
        3'b100:         w_dig = 3'b110;
        3'b101, 3'b110: w_dig = 3'b101;
        default:        w_dig = 3'b000;
      endcase
      if ((i_n_ap == 4'd0) || ((j + int'(i_n_ap)) >= NDIG)) begin
        o_bpr[3*j +: 3] = w_dig;
        if (w_dig != 3'b000) begin
          o_etc = o_etc + ETC_WIDTH'(1);
        end else begin
          o_etc = o_etc;
        end
      end else begin
        o_bpr[3*j +: 3] = 3'b000;
      end
    end
  end

endmodule

// File: rtl/wbuf_bank_seq.sv
// Weight buffer bank: synchronous weight memory, sequenced shadow-tap load
// through the Booth encoder, and shadow-to-active swap.
module wbuf_bank_seq
  import wbuf_pkg::*;
#(
  parameter int NB_TAPS      = 5,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ETC_WIDTH    = 4,
  parameter int BPR_WIDTH    = bpr_width(WEIGHT_WIDTH),
  parameter int DEPTH        = 72,
  parameter int ADDR_W       = clog2(DEPTH),
  parameter int CNT_W        = clog2(NB_TAPS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]         wr_data,
  input  logic                            load_start,
  input  logic [ADDR_W-1:0]               load_base,
  input  logic [CNT_W-1:0]                load_ntaps,
  input  logic [3:0]                      n_ap,
  input  logic                            swap,
  output logic                            load_busy,
  output logic                            load_done,
  output logic [NB_TAPS*WEIGHT_WIDTH-1:0] WRegs,
  output logic [NB_TAPS*BPR_WIDTH-1:0]    WBPRs,
  output logic [NB_TAPS*ETC_WIDTH-1:0]    WETCs
);

  wbuf_state_t r_state;
  wbuf_state_t w_state_nxt;

  logic [WEIGHT_WIDTH-1:0] r_mem [DEPTH];
  logic [WEIGHT_WIDTH-1:0] r_rd_data;

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_ntaps;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_rd_idx;
  logic              r_rd_vld;
  logic [3:0]        r_n_ap;
  logic              r_swap_pend;
  logic              r_load_busy;
  logic              r_load_done;

  logic [NB_TAPS*WEIGHT_WIDTH-1:0] r_sh_wreg;
  logic [NB_TAPS*BPR_WIDTH-1:0]    r_sh_bpr;
  logic [NB_TAPS*ETC_WIDTH-1:0]    r_sh_etc;
  logic [NB_TAPS*WEIGHT_WIDTH-1:0] r_act_wreg;
  logic [NB_TAPS*BPR_WIDTH-1:0]    r_act_bpr;
  logic [NB_TAPS*ETC_WIDTH-1:0]    r_act_etc;

  logic                  w_issue;
  logic                  w_accept;
  logic                  w_copy;
  logic [CNT_W-1:0]      w_clamp;
  logic [ADDR_W-1:0]     w_addr_nxt;
  logic [BPR_WIDTH-1:0]  w_enc_bpr;
  logic [ETC_WIDTH-1:0]  w_enc_etc;
  int                    w_tap;

  BPEB_Enc_ETC #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .BPR_WIDTH    (BPR_WIDTH),
    .ETC_WIDTH    (ETC_WIDTH)
  ) u_enc (
    .i_weight (r_rd_data),
    .i_n_ap   (r_n_ap),
    .o_bpr    (w_enc_bpr),
    .o_etc    (w_enc_etc)
  );

  // Next state, read issue and swap-copy decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_clamp     = (load_ntaps > CNT_W'(NB_TAPS)) ? CNT_W'(NB_TAPS) : load_ntaps;
    w_addr_nxt  = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
    w_tap       = int'(r_rd_idx);
    w_copy      = ((r_state == S_IDLE) && swap) ||
                  ((r_state == S_DONE) && (r_swap_pend || swap));
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_clamp == '0) ? S_DONE : S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_issue = 1'b1;
        if (r_rd_cnt == (r_ntaps - CNT_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Weight memory: not reset, read-before-write on address collision.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_W'(DEPTH))) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (w_issue) begin
      r_rd_data <= (r_addr < ADDR_W'(DEPTH)) ? r_mem[r_addr] : '0;
    end
  end

  // Sequencer state, shadow tap fill and active-tap swap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
      r_swap_pend <= 1'b0;
      r_addr      <= '0;
      r_ntaps     <= '0;
      r_rd_cnt    <= '0;
      r_rd_idx    <= '0;
      r_rd_vld    <= 1'b0;
      r_n_ap      <= '0;
      r_sh_wreg   <= '0;
      r_sh_bpr    <= '0;
      r_sh_etc    <= '0;
      r_act_wreg  <= '0;
      r_act_bpr   <= '0;
      r_act_etc   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_busy <= (w_state_nxt != S_IDLE);
      r_load_done <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        r_addr   <= load_base;
        r_ntaps  <= w_clamp;
        r_n_ap   <= n_ap;
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_addr   <= w_addr_nxt;
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end

      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_idx <= r_rd_cnt;
      end

      if (r_rd_vld) begin
        r_sh_wreg[w_tap*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= r_rd_data;
        r_sh_bpr[w_tap*BPR_WIDTH +: BPR_WIDTH]        <= w_enc_bpr;
        r_sh_etc[w_tap*ETC_WIDTH +: ETC_WIDTH]        <= w_enc_etc;
      end

      // A swap seen mid-load is held and applied as the load_done cycle ends.
      if (r_state == S_DONE) begin
        r_swap_pend <= 1'b0;
      end else if (swap && (r_state != S_IDLE)) begin
        r_swap_pend <= 1'b1;
      end

      if (w_copy) begin
        r_act_wreg <= r_sh_wreg;
        r_act_bpr  <= r_sh_bpr;
        r_act_etc  <= r_sh_etc;
      end
    end
  end

  assign load_busy = r_load_busy;
  assign load_done = r_load_done;
  assign WRegs     = r_act_wreg;
  assign WBPRs     = r_act_bpr;
  assign WETCs     = r_act_etc;

endmodule

// File: tb/tb_wbuf_bank_seq.sv
// Directed self-checking bench for wbuf_bank_seq.
module tb_wbuf_bank_seq;

  localparam int NT = 5;
  localparam int WW = 16;
  localparam int EW = 4;
  localparam int BW = 24;
  localparam int AW = 7;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [WW-1:0]  wr_data;
  logic           load_start;
  logic [AW-1:0]  load_base;
  logic [CW-1:0]  load_ntaps;
  logic [3:0]     n_ap;
  logic           swap;
  logic           load_busy;
  logic           load_done;
  logic [NT*WW-1:0] WRegs;
  logic [NT*BW-1:0] WBPRs;
  logic [NT*EW-1:0] WETCs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wbuf_bank_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_start (load_start),
    .load_base  (load_base),
    .load_ntaps (load_ntaps),
    .n_ap       (n_ap),
    .swap       (swap),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .WRegs      (WRegs),
    .WBPRs      (WBPRs),
    .WETCs      (WETCs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wmem(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Drives load_start for one edge (E0); optional simultaneous swap.
  task automatic start(input logic [AW-1:0] b, input logic [CW-1:0] n,
                       input logic [3:0] ap, input logic sw);
    load_start = 1'b1; load_base = b; load_ntaps = n; n_ap = ap; swap = sw;
    tick();
    load_start = 1'b0; swap = 1'b0;
  endtask

  // Counts edges until load_done is seen, bounded.
  task automatic wait_done(input string tag, input int exp);
    int c;
    c = 0;
    while (!load_done && c < 20) begin
      tick();
      c++;
    end
    check(tag, 128'(c), 128'(exp));
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    logic [NT*WW-1:0] a1, s2, a3, a6;
    int seen;
    a1 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    s2 = {16'h5555, 16'h0101, 16'h0003, 16'h7171, 16'h7070};
    a3 = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222};
    a6 = {16'h6666, 16'h5555, 16'h3333, 16'h2222, 16'h1111};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_start = 1'b0; load_base = '0; load_ntaps = '0; n_ap = '0; swap = 1'b0;
    repeat (3) tick();
    check("rst_busy", 128'(load_busy), 128'(0));
    check("rst_done", 128'(load_done), 128'(0));
    check("rst_wregs", 128'(WRegs), 128'(0));
    check("rst_wbprs", 128'(WBPRs), 128'(0));
    check("rst_wetcs", 128'(WETCs), 128'(0));
    rst_n = 1'b1;
    tick();

    wmem(7'd10, 16'h1111); wmem(7'd11, 16'h2222); wmem(7'd12, 16'h3333);
    wmem(7'd13, 16'h4444); wmem(7'd14, 16'h5555); wmem(7'd15, 16'h6666);
    wmem(7'd70, 16'h7070); wmem(7'd71, 16'h7171);
    wmem(7'd0, 16'h0003);  wmem(7'd1, 16'h0101);

    // Basic 5-tap load from 10
    start(7'd10, 3'd5, 4'd0, 1'b0);
    check("t1_busy_e0", 128'(load_busy), 128'(1));
    check("t1_done_e0", 128'(load_done), 128'(0));
    wait_done("t1_done_lat", 6);
    check("t1_busy_done", 128'(load_busy), 128'(1));
    check("t1_act_hold", 128'(WRegs), 128'(0));
    tick();
    check("t1_done_pulse", 128'(load_done), 128'(0));
    check("t1_busy_end", 128'(load_busy), 128'(0));
    do_swap();
    check("t1_wregs", 128'(WRegs), 128'(a1));
    check("t1_bpr0", 128'(WBPRs[0 +: BW]), 128'(24'h041041));
    check("t1_etc0", 128'(WETCs[0 +: EW]), 128'(4));
    check("t1_bpr1", 128'(WBPRs[BW +: BW]), 128'(24'h38E38E));
    check("t1_etc1", 128'(WETCs[EW +: EW]), 128'(8));

    // Wrapping 4-tap load from 70 with n_ap=4, no swap yet
    start(7'd70, 3'd4, 4'd4, 1'b0);
    wait_done("t2_done_lat", 5);
    tick();
    check("t2_act_hold", 128'(WRegs), 128'(a1));

    // Zero-tap load: immediate done, shadow untouched
    start(7'd20, 3'd0, 4'd0, 1'b0);
    check("t4_done_e0", 128'(load_done), 128'(1));
    check("t4_busy_e0", 128'(load_busy), 128'(1));
    tick();
    check("t4_done_end", 128'(load_done), 128'(0));
    check("t4_busy_end", 128'(load_busy), 128'(0));

    // Swap with load_start copies pre-load shadow; ntaps=7 clamps to 5; swap at E2 pends
    start(7'd11, 3'd7, 4'd0, 1'b1);
    check("t5_swap_start", 128'(WRegs), 128'(s2));
    check("t5_bpr2", 128'(WBPRs[2*BW +: BW]), 128'(0));
    check("t5_etc2", 128'(WETCs[2*EW +: EW]), 128'(0));
    check("t5_bpr3", 128'(WBPRs[3*BW +: BW]), 128'(24'h001000));
    check("t5_etc3", 128'(WETCs[3*EW +: EW]), 128'(1));
    tick();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("t5_pend_hold", 128'(WRegs), 128'(s2));
    wait_done("t5_done_lat", 4);
    check("t5_hold_done", 128'(WRegs), 128'(s2));
    tick();
    check("t5_pend_copy", 128'(WRegs), 128'(a3));
    tick();
    check("t5_pend_clear", 128'(WRegs), 128'(a3));

    // Write to address 12 in the cycle its read is issued: tap sees old word
    start(7'd10, 3'd3, 4'd4, 1'b0);
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 7'd12; wr_data = 16'hABCD;
    tick();
    wr_en = 1'b0;
    wait_done("t6_done_lat", 1);
    tick();
    do_swap();
    check("t6_wregs", 128'(WRegs), 128'(a6));
    check("t6_bpr0", 128'(WBPRs[0 +: BW]), 128'(24'h041000));
    check("t6_etc0", 128'(WETCs[0 +: EW]), 128'(2));

    // Reset at E3 of a load aborts it
    start(7'd10, 3'd5, 4'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t7_busy", 128'(load_busy), 128'(0));
    check("t7_wregs", 128'(WRegs), 128'(0));
    check("t7_wbprs", 128'(WBPRs), 128'(0));
    check("t7_wetcs", 128'(WETCs), 128'(0));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_done) seen = 1;
    end
    check("t7_no_done", 128'(seen), 128'(0));

    // Memory survives reset and holds the colliding write
    start(7'd12, 3'd1, 4'd0, 1'b0);
    wait_done("t8_done_lat", 2);
    tick();
    do_swap();
    check("t8_wregs", 128'(WRegs), 128'({64'h0, 16'hABCD}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wbuf_bank_seq.md
WBUF_BANK_SEQ -- requirements
Module: wbuf_bank_seq

Interface
REQ-001 Parameter NB_TAPS, 5, number of tap register slots.
REQ-002 Parameter WEIGHT_WIDTH, 16, weight word width, also the memory word width.
REQ-003 Parameter ETC_WIDTH, 4, ETC field width per tap.
REQ-004 Parameter BPR_WIDTH, ((WEIGHT_WIDTH+1)/2)*3, BPR field width per tap.
REQ-005 Parameter DEPTH, 72, memory words; ADDR_W = ceil(log2(DEPTH)), CNT_W = ceil(log2(NB_TAPS+1)).
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 wr_en  in  1  memory write strobe.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  WEIGHT_WIDTH  write data.
REQ-011 load_start  in  1  request to load shadow taps.
REQ-012 load_base  in  ADDR_W  first read address.
REQ-013 load_ntaps  in  CNT_W  number of taps to load.
REQ-014 n_ap  in  4  encoder precision control.
REQ-015 swap  in  1  request to copy shadow taps to active taps.
REQ-016 load_busy  out  1  load in progress.
REQ-017 load_done  out  1  one-cycle pulse when the load completes.
REQ-018 WRegs / WBPRs / WETCs  out  NB_TAPS*{WEIGHT_WIDTH,BPR_WIDTH,ETC_WIDTH}  active taps; tap t occupies slice [(t+1)*W-1 -: W].

Function
REQ-019 Memory SHALL be synchronous: write on wr_en; read data registered, one-cycle latency; same-address read and write in one cycle return the old data.
REQ-020 FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-021 IDLE: load_start SHALL be accepted at edge E0 and latch base, clamp(ntaps, NB_TAPS) and n_ap; go to READ.
REQ-022 READ SHALL issue reads at addresses base+k, k=0..n-1, one per cycle; addresses wrap from DEPTH-1 to 0.
REQ-023 Encoder output for read k SHALL load shadow tap k at edge E(k+2); the last tap loads at E(n+1). DRAIN covers the final pipeline cycle.
REQ-024 DONE SHALL assert load_done for exactly the cycle after E(n+1), then return to IDLE.
REQ-025 load_busy SHALL be high from the cycle after E0 through the load_done cycle inclusive.
REQ-026 load_ntaps=0 SHALL skip READ and DRAIN: load_done pulses the cycle after E0 and no tap changes.
REQ-027 load_start while busy SHALL be ignored.
REQ-028 Shadow taps with index >= n SHALL keep their previous values.
REQ-029 Memory writes SHALL remain legal during a load; read data follows REQ-019.
REQ-030 Swap while not busy SHALL copy all shadow taps to active taps at the next edge.
REQ-031 Swap while busy SHALL set a pending flag; the copy SHALL occur at the edge ending the load_done cycle, then pending clears.
REQ-032 Swap together with load_start in IDLE SHALL copy the pre-load shadow contents, and the load SHALL proceed.
REQ-033 Active outputs SHALL change only on a swap.

Reset
REQ-034 While rst_n=0 at an edge: FSM to IDLE, load_busy=0, load_done=0, pending=0, all shadow and active taps=0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset mid-load SHALL abort the load with no load_done pulse.

Structure
REQ-037 Package wbuf_pkg SHALL hold the FSM state typedef, the clog2 function and the BPR-width function.
REQ-038 Encoder SHALL be one instance of BPEB_Enc_ETC on the memory read-data path; the memory SHALL be an inferred array in this module.

Verification
REQ-039 Write 0x1111..0x5555 at addresses 10..14; start base=10, ntaps=5 at E0 -> load_done at the cycle after E6; no output change; swap -> WRegs tap0..4 = 0x1111..0x5555.
REQ-040 Base=70, ntaps=4, DEPTH=72 -> taps load from addresses 70, 71, 0, 1.
REQ-041 Swap at E2 of a 5-tap load -> active unchanged until the edge ending load_done, then equal to the new shadow.
REQ-042 ntaps=0 -> load_done the cycle after E0, taps unchanged; ntaps=7 -> behaves as 5.
REQ-043 Write 0xABCD to address 12 in the cycle read 12 issues -> tap gets the old word; rst_n=0 at E3 -> no load_done, all outputs 0.
